dmem_arbiter: RTL and testbench

//  Two-requester arbiter for the single-port data BRAM behind the MEM stage.

---
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data BRAM behind the MEM stage.
// The CPU load/store path normally wins. The DMA/CP2 requester gets one forced
// grant after MAX_WAIT consecutive refused cycles. A LAT-deep tag pipeline
// returns BRAM read data to the requester that issued the read.
module dmem_arbiter #(
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 32,
  parameter int LAT      = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  // CPU load/store port
  input  logic                cpu_req,
  input  logic [DATA_W/8-1:0] cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_gnt,
  output logic                cpu_stall,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata,
  // DMA / CP2 port
  input  logic                dma_req,
  input  logic [DATA_W/8-1:0] dma_we,
  input  logic [ADDR_W-1:0]   dma_addr,
  input  logic [DATA_W-1:0]   dma_wdata,
  output logic                dma_gnt,
  output logic                dma_rvalid,
  output logic [DATA_W-1:0]   dma_rdata,
  // BRAM port
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_wea,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_e;

  // One in-flight access: does it expect read data, and who gets it.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  logic [CNT_W-1:0] wait_cnt;
  logic             force_dma;
  logic             any_gnt;
  logic             issue_read;
  tag_t             tag_q [LAT];
  tag_t             tag_out;

  // Grant: CPU has priority unless the DMA has starved for MAX_WAIT cycles.
  assign force_dma = dma_req && (wait_cnt == WAIT_LIMIT);
  assign dma_gnt   = dma_req && (!cpu_req || force_dma);
  assign cpu_gnt   = cpu_req && !dma_gnt;
  assign cpu_stall = cpu_req && !cpu_gnt;
  assign any_gnt   = cpu_gnt || dma_gnt;

  // Steer the winner's request onto the BRAM port; idle port is driven to zero.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    mem_en    = 1'b0;
    mem_wea   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dma_gnt) begin
      mem_en    = 1'b1;
      mem_wea   = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_wea   = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  assign issue_read = any_gnt && (mem_wea == BE_W'(0));

  // Starvation counter: counts consecutive refused DMA cycles, saturating.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    if (reset) begin
      wait_cnt <= '0;
    end else if (!dma_req || dma_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_LIMIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Return-tag pipeline: tracks each issued read until its data leaves the BRAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the tag stages are reset because stale valid bits would emit phantom
      // responses; read data itself is never stored here, so nothing else needs clearing.
      for (int i = 0; i < LAT; i++) begin
        tag_q[i].valid <= 1'b0;
        tag_q[i].owner <= OWNER_CPU;
      end
    end else begin
      tag_q[0].valid <= issue_read;
      tag_q[0].owner <= dma_gnt ? OWNER_DMA : OWNER_CPU;
      for (int i = 1; i < LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_out    = tag_q[LAT-1];
  assign cpu_rvalid = tag_out.valid && (tag_out.owner == OWNER_CPU);
  assign dma_rvalid = tag_out.valid && (tag_out.owner == OWNER_DMA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// traffic, all compared every cycle against a transaction-level reference model
// (starvation count, response queue with due cycles, shadow memory).
module tb_dmem_arbiter;

  localparam int ADDR_W   = 30;
  localparam int DATA_W   = 32;
  localparam int LAT      = 2;
  localparam int MAX_WAIT = 4;
  localparam int BE_W     = DATA_W / 8;
  localparam int DEPTH    = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, dma_req;
  logic [BE_W-1:0]   cpu_we, dma_we;
  logic [ADDR_W-1:0] cpu_addr, dma_addr;
  logic [DATA_W-1:0] cpu_wdata, dma_wdata;
  logic              cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [DATA_W-1:0] cpu_rdata, dma_rdata;
  logic              mem_en;
  logic [BE_W-1:0]   mem_wea;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(LAT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_wea(mem_wea), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- BRAM model driven only by the DUT's mem_* port ----------------
  logic [DATA_W-1:0] bram [DEPTH];
  logic [DATA_W-1:0] rpipe [LAT];
  assign mem_rdata = rpipe[LAT-1];

  // Read-before-write BRAM with LAT-cycle read pipeline; idle cycles inject garbage.
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
    if (mem_en) begin
      rpipe[0] <= bram[mem_addr[7:0]];
      for (int b = 0; b < BE_W; b++)
        if (mem_wea[b]) bram[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end else begin
      rpipe[0] <= $urandom;
    end
  end

  // ---------------- Reference model ----------------
  typedef struct {
    int                due;
    bit                to_dma;
    logic [DATA_W-1:0] data;
  } resp_t;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  resp_t             rq[$];
  int                refused;   // consecutive cycles the DMA was turned away
  int                cyc;
  int                n_vec;
  int                n_miss;
  bit                exp_dma_gnt, exp_cpu_gnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s @cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < BE_W; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // One clock cycle: drive, check comb and response outputs, clock, advance model.
  task automatic step(input bit c_req, input logic [BE_W-1:0] c_we, input logic [ADDR_W-1:0] c_addr,
                      input logic [DATA_W-1:0] c_wd, input bit d_req, input logic [BE_W-1:0] d_we,
                      input logic [ADDR_W-1:0] d_addr, input logic [DATA_W-1:0] d_wd, input bit rst);
    bit                win_dma, win_any, exp_cv, exp_dv;
    logic [BE_W-1:0]   w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wd, exp_cd, exp_dd;
    resp_t             r;
    @(negedge clk);
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
    dma_req = d_req; dma_we = d_we; dma_addr = d_addr; dma_wdata = d_wd;
    reset   = rst;
    #1;
    // Who should win: CPU first, unless the DMA has waited MAX_WAIT cycles already.
    exp_dma_gnt = d_req && (!c_req || refused >= MAX_WAIT);
    exp_cpu_gnt = c_req && !exp_dma_gnt;
    win_dma = exp_dma_gnt;
    win_any = exp_dma_gnt || exp_cpu_gnt;
    w_we    = !win_any ? '0 : (win_dma ? d_we : c_we);
    w_addr  = !win_any ? '0 : (win_dma ? d_addr : c_addr);
    w_wd    = !win_any ? '0 : (win_dma ? d_wd : c_wd);
    check("cpu_gnt", 64'(cpu_gnt), 64'(exp_cpu_gnt));
    check("dma_gnt", 64'(dma_gnt), 64'(exp_dma_gnt));
    check("cpu_stall", 64'(cpu_stall), 64'(c_req && !exp_cpu_gnt));
    check("mem_en", 64'(mem_en), 64'(win_any));
    check("mem_wea", 64'(mem_wea), 64'(w_we));
    check("mem_addr", 64'(mem_addr), 64'(w_addr));
    check("mem_wdata", 64'(mem_wdata), 64'(w_wd));
    // Response due this cycle, if any.
    exp_cv = 1'b0; exp_dv = 1'b0; exp_cd = '0; exp_dd = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      if (r.to_dma) begin exp_dv = 1'b1; exp_dd = r.data; end
      else          begin exp_cv = 1'b1; exp_cd = r.data; end
    end
    check("cpu_rvalid", 64'(cpu_rvalid), 64'(exp_cv));
    check("cpu_rdata", 64'(cpu_rdata), 64'(exp_cd));
    check("dma_rvalid", 64'(dma_rvalid), 64'(exp_dv));
    check("dma_rdata", 64'(dma_rdata), 64'(exp_dd));
    @(posedge clk);
    // Model update after the edge. The access itself happens even during reset.
    if (win_any && w_we == '0 && !rst)
      rq.push_back('{due: cyc + LAT, to_dma: win_dma, data: ref_mem[w_addr[7:0]]});
    if (win_any && w_we != '0)
      ref_mem[w_addr[7:0]] = merge(ref_mem[w_addr[7:0]], w_wd, w_we);
    if (rst) begin
      rq.delete();
      refused = 0;
    end else if (d_req && !exp_dma_gnt) begin
      refused = (refused < MAX_WAIT) ? refused + 1 : MAX_WAIT;
    end else begin
      refused = 0;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0, '0, '0, '0, 0);
  endtask

  // ---------------- Stimulus ----------------
  initial begin
    bit                d_pend;
    logic [BE_W-1:0]   d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wd;
    int                dma_grants;

    n_vec = 0; n_miss = 0; cyc = 0; refused = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bram[i]    = $urandom;
      ref_mem[i] = bram[i];
    end
    bram[8'h10]    = 32'hDEAD_BEEF;
    ref_mem[8'h10] = 32'hDEAD_BEEF;
    for (int i = 0; i < LAT; i++) rpipe[i] = '0;

    cpu_req = 0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = '0; dma_addr = '0; dma_wdata = '0;
    reset   = 1'b1;
    repeat (3) @(posedge clk);

    // Reset state: first checked cycles must show no responses and idle port.
    idle(2);

    // 1: lone CPU read of 0xDEADBEEF, data two cycles later.
    step(1, '0, 30'h10, '0, 0, '0, '0, '0, 0);
    idle(3);

    // 2: both requesters held for 10 cycles; DMA forced on the 5th.
    dma_grants = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, '0, 30'(i), '0, 1, '0, 30'h40, '0, 0);
      if (exp_dma_gnt) dma_grants++;
    end
    idle(3);

    // 3: alternating reads issued back to back.
    step(1, '0, 30'h1, '0, 0, '0, '0, '0, 0);
    step(0, '0, '0, '0, 1, '0, 30'h2, '0, 0);
    step(1, '0, 30'h3, '0, 0, '0, '0, '0, 0);
    idle(3);

    // 4: DMA partial write, then CPU reads the word back.
    step(0, '0, '0, '0, 1, 4'b0011, 30'h20, 32'h0000_ABCD, 0);
    idle(1);
    step(1, '0, 30'h20, '0, 0, '0, '0, '0, 0);
    idle(3);
    check("t4_low_half", 64'(ref_mem[8'h20][15:0]), 64'h0000_ABCD);

    // 5: reset lands one cycle after a CPU read issues; the response is dropped.
    step(1, '0, 30'h10, '0, 0, '0, '0, '0, 0);
    step(0, '0, '0, '0, 0, '0, '0, '0, 1);
    idle(3);
    // Counter restart after reset: DMA must again wait a full MAX_WAIT cycles.
    for (int i = 0; i < MAX_WAIT + 2; i++) step(1, '0, 30'h5, '0, 1, '0, 30'h6, '0, 0);
    idle(3);

    // 6: idle cycles.
    idle(2);

    check("t2_dma_grants", 64'(dma_grants), 64'd2);

    // Random traffic; DMA holds its request until granted.
    d_pend = 0; d_we = '0; d_addr = '0; d_wd = '0;
    for (int i = 0; i < 600; i++) begin
      bit               c_req, rst;
      logic [BE_W-1:0]  c_we;
      if (!d_pend && ($urandom_range(0, 2) == 0)) begin
        d_pend = 1;
        d_we   = ($urandom_range(0, 1) == 0) ? '0 : BE_W'($urandom);
        d_addr = 30'($urandom_range(0, DEPTH - 1));
        d_wd   = $urandom;
      end
      c_req = ($urandom_range(0, 3) != 0);
      c_we  = ($urandom_range(0, 1) == 0) ? '0 : BE_W'($urandom);
      rst   = ($urandom_range(0, 79) == 0);
      step(c_req, c_we, 30'($urandom_range(0, DEPTH - 1)), $urandom,
           d_pend, d_we, d_addr, d_wd, rst);
      if (exp_dma_gnt) d_pend = 0;
    end
    idle(LAT + 1);
    check("resp_queue_drained", 64'(rq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
